dcache_mshr: RTL

//  Data-cache responder for the LSQ load/store request ports. Direct-mapped, write-through,
//  no-write-allocate cache of 8-byte blocks, with an MSHR table tracking outstanding load misses.

---
 rtl/dcache_mshr.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dcache_mshr.sv
// Direct-mapped write-through, no-write-allocate data cache with an MSHR table for load misses.
// Optional build macro DCACHE_MSHR_MERGE_EN: a load miss to a block already pending is acked without a new request.
module dcache_mshr #(
   parameter int DC_LINES = 32,
   parameter int MSHR_NUM = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_en_i,
   input  logic [63:0] ld_addr_i,
   input  logic        st_en_i,
   input  logic [63:0] st_addr_i,
   input  logic [63:0] st_data_i,
   output logic        hit_o,
   output logic [63:0] data_o,
   output logic        mshr_ld_ack_o,
   output logic        mshr_st_ack_o,
   output logic        mshr_vld_o,
   output logic [63:0] mshr_addr_o,
   output logic        mshr_stall_o,
   output logic [1:0]  mem_cmd_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_data_o,
   input  logic [3:0]  mem_resp_i,
   input  logic [63:0] mem_data_i,
   input  logic [3:0]  mem_tag_i
);

   localparam int IDX_W = $clog2(DC_LINES);
   localparam int TAG_W = 61 - IDX_W;
   localparam int SEL_W = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_LOAD  = 2'd1,
      CMD_STORE = 2'd2
   } mem_cmd_e;

   logic [DC_LINES-1:0] line_vld_q;
   logic [TAG_W-1:0]    line_tag_q  [DC_LINES];
   logic [63:0]         line_data_q [DC_LINES];

   logic [MSHR_NUM-1:0] mshr_vld_q, mshr_vld_d;
   logic [60:0]         mshr_blk_q  [MSHR_NUM];
   logic [3:0]          mshr_mtag_q [MSHR_NUM];

   logic [60:0]      ld_blk, st_blk, fill_blk;
   logic [IDX_W-1:0] ld_idx, st_idx, fill_idx;
   logic [TAG_W-1:0] ld_tag, st_tag, fill_tag;

   assign ld_blk = ld_addr_i[63:3];
   assign ld_idx = ld_addr_i[3+IDX_W-1:3];
   assign ld_tag = ld_addr_i[63:3+IDX_W];
   assign st_blk = st_addr_i[63:3];
   assign st_idx = st_addr_i[3+IDX_W-1:3];
   assign st_tag = st_addr_i[63:3+IDX_W];

   logic             fill_hit, free_any, ld_pending, st_block;
   logic [SEL_W-1:0] fill_sel, free_sel;

   // Table scan: descending loops leave the lowest matching/free entry selected.
   always_comb begin
      fill_hit   = 1'b0;
      fill_sel   = '0;
      free_any   = 1'b0;
      free_sel   = '0;
      ld_pending = 1'b0;
      st_block   = 1'b0;
      for (int i = MSHR_NUM - 1; i >= 0; i--) begin
         if (mshr_vld_q[i] && (mem_tag_i != 4'd0) && (mshr_mtag_q[i] == mem_tag_i)) begin
            fill_hit = 1'b1;
            fill_sel = SEL_W'(i);
         end
         if (!mshr_vld_q[i]) begin
            free_any = 1'b1;
            free_sel = SEL_W'(i);
         end
         if (mshr_vld_q[i] && (mshr_blk_q[i] == ld_blk)) ld_pending = 1'b1;
         if (mshr_vld_q[i] && (mshr_blk_q[i] == st_blk)) st_block = 1'b1;
      end
   end

   assign fill_blk = mshr_blk_q[fill_sel];
   assign fill_idx = fill_blk[IDX_W-1:0];
   assign fill_tag = fill_blk[60:IDX_W];

   logic ld_line_hit, st_line_hit, resp_ok;
   logic st_issue, ld_miss, ld_issue, ld_alloc, merge_ack, st_ack, st_we;

   assign ld_line_hit = line_vld_q[ld_idx] && (line_tag_q[ld_idx] == ld_tag);
   assign st_line_hit = line_vld_q[st_idx] && (line_tag_q[st_idx] == st_tag);
   assign resp_ok     = (mem_resp_i != 4'd0);

   // Store owns the memory port first; a load miss only proceeds when the port and a fill slot are free.
   assign st_issue = st_en_i && !st_block;
   assign ld_miss  = ld_en_i && !ld_line_hit && !fill_hit && !st_issue;
   assign ld_issue = ld_miss && !ld_pending && free_any;
   assign ld_alloc = ld_issue && resp_ok;
   assign st_ack   = st_issue && resp_ok;
`ifdef DCACHE_MSHR_MERGE_EN
   assign merge_ack = ld_miss && ld_pending;
`else
   assign merge_ack = 1'b0;
`endif
   // A fill to the same index overrides the store data.
   assign st_we = st_ack && st_line_hit && !(fill_hit && (fill_idx == st_idx));

   always_comb begin
      hit_o         = 1'b0;
      data_o        = '0;
      mshr_ld_ack_o = 1'b0;
      mshr_st_ack_o = 1'b0;
      mshr_vld_o    = 1'b0;
      mshr_addr_o   = '0;
      mshr_stall_o  = 1'b0;
      mem_cmd_o     = CMD_NONE;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      if (!rst) begin
         mshr_vld_o    = fill_hit;
         hit_o         = ld_en_i && ld_line_hit && !fill_hit;
         mshr_ld_ack_o = ld_alloc || merge_ack;
         mshr_st_ack_o = st_ack;
         mshr_stall_o  = !free_any;
         if (fill_hit) begin
            mshr_addr_o = {fill_blk, 3'b000};
            data_o      = mem_data_i;
         end else if (hit_o) begin
            data_o = line_data_q[ld_idx];
         end
         if (st_issue) begin
            mem_cmd_o  = CMD_STORE;
            mem_addr_o = st_addr_i;
            mem_data_o = st_data_i;
         end else if (ld_issue) begin
            mem_cmd_o  = CMD_LOAD;
            mem_addr_o = {ld_blk, 3'b000};
         end
      end
   end

   always_comb begin
      mshr_vld_d = mshr_vld_q;
      if (fill_hit) mshr_vld_d[fill_sel] = 1'b0;
      if (ld_alloc) mshr_vld_d[free_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_vld_q <= '0;
         mshr_vld_q <= '0;
      end else begin
         mshr_vld_q <= mshr_vld_d;
         if (fill_hit) line_vld_q[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (fill_hit) begin
            line_tag_q[fill_idx]  <= fill_tag;
            line_data_q[fill_idx] <= mem_data_i;
         end
         if (st_we) line_data_q[st_idx] <= st_data_i;
         if (ld_alloc) begin
            mshr_blk_q[free_sel]  <= ld_blk;
            mshr_mtag_q[free_sel] <= mem_resp_i;
         end
      end
   end

endmodule
